press_repeater: RTL and testbench



---
 rtl/press_repeater_pkg.sv | 17 +
 rtl/press_repeater_load_timer.sv | 36 +++
 rtl/press_repeater.sv | 134 +++++++++++++
 tb/tb_press_repeater.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/press_repeater_pkg.sv
// Shared types and constants for the press/auto-repeat event generator.
package press_repeater_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] REPEAT_CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == REPEAT_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/press_repeater_load_timer.sv
// Loadable down-counter shared by the hold delay and the repeat period.
module load_timer #(
    parameter int unsigned TMR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    // Stops at zero so a late expiry never wraps into a bogus long delay.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/press_repeater.sv
// Turns a debounced button level into press, auto-repeat and release events.
module press_repeater
    import press_repeater_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned TMR_W         =
        $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_i,
    input  logic       enable_i,
    output logic       press_o,
    output logic       repeat_pulse_o,
    output logic       step_o,
    output logic       release_o,
    output logic       held_o,
    output logic [7:0] repeat_count_o
);

    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             press_q, press_d;
    logic             rep_q, rep_d;
    logic             step_q;
    logic             rel_q, rel_d;
    logic             held_q;
    logic [7:0]       cnt_q, cnt_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    load_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        press_d      = 1'b0;
        rep_d        = 1'b0;
        rel_d        = 1'b0;
        cnt_d        = cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_i && enable_i) begin
                    state_d      = HOLD;
                    press_d      = 1'b1;
                    cnt_d        = 8'd0;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end else if (btn_i) begin
                    state_d = LOCKOUT;
                end
            end

            // Disable beats release, and release beats timer expiry.
            HOLD, REPEAT: begin
                tmr_dec = 1'b1;
                if (!enable_i) begin
                    state_d = LOCKOUT;
                end else if (!btn_i) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else if (tmr_zero) begin
                    state_d      = REPEAT;
                    rep_d        = 1'b1;
                    cnt_d        = sat_inc(cnt_q);
                    tmr_load     = 1'b1;
                    tmr_load_val = REPEAT_LOAD;
                end
            end

            LOCKOUT: begin
                if (!btn_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            press_q <= 1'b0;
            rep_q   <= 1'b0;
            step_q  <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            rep_q   <= rep_d;
            step_q  <= press_d | rep_d;
            rel_q   <= rel_d;
            held_q  <= (state_d == HOLD) || (state_d == REPEAT);
            cnt_q   <= cnt_d;
        end
    end

    assign press_o        = press_q;
    assign repeat_pulse_o = rep_q;
    assign step_o         = step_q;
    assign release_o      = rel_q;
    assign held_o         = held_q;
    assign repeat_count_o = cnt_q;

    a_no_press_and_repeat : assert property (@(posedge clk) disable iff (reset)
        !(press_q && rep_q));
    a_no_back_to_back_step : assert property (@(posedge clk) disable iff (reset)
        step_q |=> !step_q);

endmodule

// File: tb/tb_press_repeater.sv
// Directed bench for press_repeater with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_press_repeater;

    logic       clk;
    logic       reset;
    logic       btn;
    logic       enable;
    logic       press;
    logic       repeat_pulse;
    logic       step;
    logic       rel;
    logic       held;
    logic [7:0] repeat_count;

    int tests_run;
    int tests_failed;

    // Observed flags packed as {press, repeat_pulse, step, release, held}.
    logic [4:0] obs;
    assign obs = {press, repeat_pulse, step, rel, held};

    press_repeater #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_i          (btn),
        .enable_i       (enable),
        .press_o        (press),
        .repeat_pulse_o (repeat_pulse),
        .step_o         (step),
        .release_o      (rel),
        .held_o         (held),
        .repeat_count_o (repeat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] flags(input logic p, input logic r,
                                         input logic rl, input logic h);
        return {p, r, p | r, rl, h};
    endfunction

    // Advance one edge; outputs then reflect that edge and inputs may change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn    = 1'b0;
        enable = 1'b1;
        reset  = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn    = 1'b1;
        enable = 1'b1;
        repeat (2) cyc();
        tests_run++;
        if (obs !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want %b", obs, 5'b0);
        end
        tests_run++;
        if (repeat_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_count got %0d want 0", repeat_count);
        end
        settle();
        tests_run++;
        if (obs !== 5'b0) begin
            tests_failed++;
            $display("FAIL idle_flags got %b want %b", obs, 5'b0);
        end
    endtask

    task automatic test_tap();
        logic [4:0] exp;
        btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            exp = flags(i == 1, 1'b0, i == 4, (i >= 1) && (i <= 3));
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL tap c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== 8'd0) begin
                tests_failed++;
                $display("FAIL tap c%0d count got %0d want 0", i, repeat_count);
            end
            btn = (i + 1 <= 3);
        end
        settle();
    endtask

    task automatic test_long_hold();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        btn = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            cyc();
            exp = flags(i == 1, (i == 9) || (i == 13) || (i == 17), i == 21, i <= 20);
            exp_cnt = (i < 9) ? 8'd0 : (i < 13) ? 8'd1 : (i < 17) ? 8'd2 : 8'd3;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL long_hold c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== exp_cnt) begin
                tests_failed++;
                $display("FAIL long_hold c%0d count got %0d want %0d", i, repeat_count, exp_cnt);
            end
            btn = (i + 1 <= 20);
        end
        settle();
    endtask

    task automatic test_collision();
        logic [4:0] exp;
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            exp = flags(i == 1, 1'b0, i == 9, i <= 8);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL collision c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== 8'd0) begin
                tests_failed++;
                $display("FAIL collision c%0d count got %0d want 0", i, repeat_count);
            end
            btn = (i + 1 <= 8);
        end
        settle();
    endtask

    task automatic test_lockout();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        btn    = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            exp = flags((i == 1) || (i == 27), (i == 9) || (i == 13), i == 28,
                        (i <= 13) || (i == 27));
            exp_cnt = (i < 9) ? 8'd0 : (i < 13) ? 8'd1 : (i < 27) ? 8'd2 : 8'd0;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL lockout c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== exp_cnt) begin
                tests_failed++;
                $display("FAIL lockout c%0d count got %0d want %0d", i, repeat_count, exp_cnt);
            end
            btn    = (i + 1 <= 25) || (i + 1 == 27);
            enable = !((i + 1 >= 14) && (i + 1 <= 20));
        end
        settle();
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        btn = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            cyc();
            exp = flags((i == 1) || (i == 12), (i == 9) || (i == 20), i == 21,
                        (i <= 10) || ((i >= 12) && (i <= 20)));
            exp_cnt = ((i >= 9) && (i <= 10)) || (i >= 20) ? 8'd1 : 8'd0;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== exp_cnt) begin
                tests_failed++;
                $display("FAIL reset_mid c%0d count got %0d want %0d", i, repeat_count, exp_cnt);
            end
            reset = (i + 1 == 11);
            btn   = (i + 1 <= 20);
        end
        settle();
    endtask

    task automatic test_saturation();
        logic [4:0] exp;
        logic [7:0] exp_cnt;
        int         reps;
        btn = 1'b1;
        for (int i = 1; i <= 1050; i++) begin
            cyc();
            exp = flags(i == 1, (i >= 9) && (i <= 1045) && (((i - 9) % 4) == 0),
                        i == 1049, i <= 1048);
            reps = (i < 9) ? 0 : ((i - 9) / 4 + 1);
            exp_cnt = (reps > 255) ? 8'd255 : 8'(reps);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL saturation c%0d flags got %b want %b", i, obs, exp);
            end
            tests_run++;
            if (repeat_count !== exp_cnt) begin
                tests_failed++;
                $display("FAIL saturation c%0d count got %0d want %0d", i, repeat_count, exp_cnt);
            end
            btn = (i + 1 <= 1048);
        end
        settle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        btn          = 1'b0;
        enable       = 1'b1;
        test_reset();
        test_tap();
        test_long_hold();
        test_collision();
        test_lockout();
        test_reset_mid_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
